// File: rtl/openpolaris_dma_scheduler.sv
// openpolaris_dma_scheduler: round-robin multi-channel descriptor front end for the openPolaris DMA core
module openpolaris_dma_scheduler #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                     dmas_clock_i,
    input  logic                     dmas_reset_ni,
    input  logic [CHANNELS-1:0]      ch_valid_i,
    output logic [CHANNELS-1:0]      ch_ready_o,
    input  logic [CHANNELS*32-1:0]   ch_src_i,
    input  logic [CHANNELS*32-1:0]   ch_dst_i,
    input  logic [CHANNELS*32-1:0]   ch_bytes_i,
    input  logic [CHANNELS*2-1:0]    ch_size_i,
    output logic [CHANNELS-1:0]      ch_done_o,
    output logic [CHANNELS-1:0]      ch_err_o,
    output logic                     core_tx_o,
    output logic [31:0]              core_src_o,
    output logic [31:0]              core_dst_o,
    output logic [31:0]              core_bytes_o,
    output logic [1:0]               core_size_o,
    input  logic                     core_busy_i,
    input  logic                     core_done_i,
    input  logic                     core_err_i,
    output logic                     sched_busy_o,
    output logic [CH_W-1:0]          sched_ch_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REPORT} state_t;
    state_t              r_state, w_next;
    logic [CH_W-1:0]     r_ptr, r_ch, w_gnt, w_idx, w_ptr_nxt;
    logic [31:0]         r_src, r_dst, r_bytes, w_bytes;
    logic [1:0]          r_size;
    logic                r_err, r_first, w_found, w_take;
    logic [CHANNELS-1:0] w_ch_vec;

    assign w_take     = dmas_reset_ni && r_state == IDLE && !core_busy_i && w_found;
    assign w_bytes    = ch_bytes_i[32*w_gnt +: 32];
    assign w_ptr_nxt  = (w_gnt == CH_W'(CHANNELS-1)) ? '0 : w_gnt + 1'b1;
    assign w_ch_vec   = CHANNELS'(1) << r_ch;
    assign core_src_o   = r_src;
    assign core_dst_o   = r_dst;
    assign core_bytes_o = r_bytes;
    assign core_size_o  = r_size;
    assign sched_ch_o   = r_ch;

    // First valid channel at or after the round-robin pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = CH_W'((int'(r_ptr) + i) % CHANNELS);
            if (!w_found && ch_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    // State register; reset drops any in-flight transfer without reporting
    always_ff @(posedge dmas_clock_i or negedge dmas_reset_ni) begin
        if (!dmas_reset_ni) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next-state logic; zero-length descriptors skip the core entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_take) w_next = (w_bytes == '0) ? REPORT : ISSUE;
            ISSUE:     w_next = WAIT_DONE;
            WAIT_DONE: if (!r_first && !core_busy_i) w_next = REPORT;
            default:   w_next = IDLE;
        endcase
    end

    // Descriptor capture, pointer advance and completion status latch
    always_ff @(posedge dmas_clock_i or negedge dmas_reset_ni) begin
        if (!dmas_reset_ni) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_bytes <= '0;
            r_size  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_first <= r_state == ISSUE;
            if (w_take) begin
                r_src   <= ch_src_i[32*w_gnt +: 32];
                r_dst   <= ch_dst_i[32*w_gnt +: 32];
                r_bytes <= w_bytes;
                r_size  <= ch_size_i[2*w_gnt +: 2];
                r_ch    <= w_gnt;
                r_ptr   <= w_ptr_nxt;
                r_err   <= 1'b0;
            end else if (r_state == WAIT_DONE && !r_first && !core_busy_i) begin
                r_err <= core_err_i | ~core_done_i;
            end
        end
    end

    // Outputs decoded from state; only ready sees the request lines
    always_comb begin
        core_tx_o    = r_state == ISSUE;
        sched_busy_o = r_state != IDLE;
        ch_ready_o   = w_take ? CHANNELS'(1) << w_gnt : '0;
        ch_done_o    = (r_state == REPORT) ? w_ch_vec : '0;
        ch_err_o     = (r_state == REPORT && r_err) ? w_ch_vec : '0;
    end
endmodule

// File: tb/tb_openpolaris_dma_scheduler.sv
// tb_openpolaris_dma_scheduler: scoreboard bench with a behavioural core model
module tb_openpolaris_dma_scheduler;
    typedef struct packed { logic [31:0] src, dst, bytes; logic [1:0] size; } tx_t;
    typedef struct packed { logic [3:0] vec; logic err; logic nz; } dn_t;

    logic         clk, rst_n;
    logic [3:0]   ch_valid_i, ch_ready_o, ch_done_o, ch_err_o;
    logic [127:0] ch_src_i, ch_dst_i, ch_bytes_i;
    logic [7:0]   ch_size_i;
    logic         core_tx_o, core_busy_i, core_done_i, core_err_i, sched_busy_o;
    logic [31:0]  core_src_o, core_dst_o, core_bytes_o;
    logic [1:0]   core_size_o, sched_ch_o;

    tx_t tx_q[$];
    dn_t done_q[$];
    int  gnt_log[$];
    int  errors = 0, checks = 0, cyc_n = 0, m_ptr = 0, prev_g = 0, clr_g = 0, fall_cyc = 0;
    int  cm_cnt = 0, cm_len = 3;
    bit  prev_hs = 0, clr = 0, oneshot = 1, cm_busy = 0, cm_pend = 0, cm_done = 1, cm_err = 0, ext_busy = 0;

    openpolaris_dma_scheduler #(.CHANNELS(4)) dut (
        .dmas_clock_i(clk), .dmas_reset_ni(rst_n),
        .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
        .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i), .ch_bytes_i(ch_bytes_i), .ch_size_i(ch_size_i),
        .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
        .core_tx_o(core_tx_o), .core_src_o(core_src_o), .core_dst_o(core_dst_o),
        .core_bytes_o(core_bytes_o), .core_size_o(core_size_o),
        .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_err_i(core_err_i),
        .sched_busy_o(sched_busy_o), .sched_ch_o(sched_ch_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_desc(input int k, input logic [31:0] s, input logic [31:0] d, input logic [31:0] b, input logic [1:0] z);
        ch_src_i[32*k +: 32]  = s;
        ch_dst_i[32*k +: 32]  = d;
        ch_bytes_i[32*k +: 32] = b;
        ch_size_i[2*k +: 2]   = z;
        ch_valid_i[k]         = 1'b1;
    endtask

    task automatic cyc();
        int  g;
        tx_t e;
        dn_t d;
        #1;
        if (prev_hs) begin
            check("ready_drop", {28'd0, ch_ready_o}, 0);
            check("sched_busy", {31'd0, sched_busy_o}, 1);
            check("sched_ch", {30'd0, sched_ch_o}, prev_g);
        end
        prev_hs = 0;
        if (ch_ready_o != 0) begin
            g = 0;
            for (int i = 3; i >= 0; i--) if (ch_valid_i[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
            check("grant", {28'd0, ch_ready_o}, 32'd1 << g);
            e.src   = ch_src_i[32*g +: 32];
            e.dst   = ch_dst_i[32*g +: 32];
            e.bytes = ch_bytes_i[32*g +: 32];
            e.size  = ch_size_i[2*g +: 2];
            if (e.bytes != 0) tx_q.push_back(e);
            d.vec = 4'(32'd1 << g);
            d.nz  = e.bytes != 0;
            d.err = d.nz && (cm_err || !cm_done);
            done_q.push_back(d);
            m_ptr = (g + 1) % 4;
            gnt_log.push_back(g);
            prev_hs = 1;
            prev_g  = g;
            if (oneshot) begin clr = 1; clr_g = g; end
        end
        @(negedge clk);
        cyc_n++;
        if (clr) begin ch_valid_i[clr_g] = 1'b0; clr = 0; end
        if (core_tx_o) begin
            if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
            else begin
                e = tx_q.pop_front();
                check("core_src", core_src_o, e.src);
                check("core_dst", core_dst_o, e.dst);
                check("core_bytes", core_bytes_o, e.bytes);
                check("core_size", {30'd0, core_size_o}, {30'd0, e.size});
            end
        end
        if ((ch_err_o & ~ch_done_o) != 0) check("err_without_done", {28'd0, ch_err_o}, 0);
        if (ch_done_o != 0) begin
            if (done_q.size() == 0) check("done_unexpected", {28'd0, ch_done_o}, 0);
            else begin
                d = done_q.pop_front();
                check("done_vec", {28'd0, ch_done_o}, {28'd0, d.vec});
                check("err_vec", {28'd0, ch_err_o}, d.err ? {28'd0, d.vec} : 0);
                if (d.nz) check("done_latency", cyc_n, fall_cyc + 1);
            end
        end
        if (cm_pend) begin
            cm_busy = 1; cm_cnt = cm_len; cm_pend = 0; core_done_i = 0; core_err_i = 0;
        end else if (cm_busy) begin
            cm_cnt--;
            if (cm_cnt == 0) begin
                cm_busy = 0; core_done_i = cm_done; core_err_i = cm_err; fall_cyc = cyc_n;
            end
        end
        if (core_tx_o) cm_pend = 1;
        core_busy_i = cm_busy | ext_busy;
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_q.size() != 0 || done_q.size() != 0 || cm_busy || cm_pend || ch_valid_i != 0) && n < 300) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        check("drain_timeout", n < 300, 1);
    endtask

    initial begin
        int n, base;
        rst_n = 0; ch_valid_i = 0; ch_src_i = 0; ch_dst_i = 0; ch_bytes_i = 0; ch_size_i = 0;
        core_busy_i = 0; core_done_i = 0; core_err_i = 0;
        for (int k = 0; k < 4; k++) set_desc(k, 32'h100 * k, 32'h200 * k, 4, 2);
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {28'd0, ch_ready_o}, 0);
        check("rst_tx", {31'd0, core_tx_o}, 0);
        check("rst_sbusy", {31'd0, sched_busy_o}, 0);
        check("rst_sch", {30'd0, sched_ch_o}, 0);
        check("rst_src", core_src_o, 0);
        check("rst_done", {28'd0, ch_done_o}, 0);
        @(negedge clk);
        rst_n = 1;

        oneshot = 0; cm_len = 2;
        n = 0;
        while (gnt_log.size() < 5 && n < 400) begin cyc(); n++; end
        ch_valid_i = 0;
        check("rr_count", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) check($sformatf("rr_order%0d", i), gnt_log[i], i % 4);
        drain();
        oneshot = 1;

        cm_len = 10;
        set_desc(1, 32'h1000, 32'h2000, 8, 2);
        drain();

        set_desc(2, 32'h3000, 32'h4000, 0, 1);
        drain();

        cm_len = 4; cm_err = 1;
        set_desc(3, 32'h5000, 32'h6000, 16, 0);
        drain();
        cm_err = 0;
        base = gnt_log.size();
        set_desc(0, 32'h7000, 32'h7100, 12, 2);
        set_desc(1, 32'h7200, 32'h7300, 6, 1);
        drain();
        check("after_err_first", gnt_log[base], 0);
        check("after_err_second", gnt_log[base + 1], 1);

        cm_done = 0;
        set_desc(2, 32'h8000, 32'h8100, 4, 2);
        drain();
        cm_done = 1;

        ext_busy = 1;
        cyc();
        set_desc(0, 32'h9000, 32'h9100, 20, 2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("ext_hold", {28'd0, ch_ready_o}, 0);
        end
        ext_busy = 0;
        core_busy_i = cm_busy;
        #1;
        check("ext_grant", {28'd0, ch_ready_o}, 1);
        drain();

        cm_len = 30;
        set_desc(1, 32'hA000, 32'hA100, 64, 2);
        n = 0;
        while (!cm_busy && n < 50) begin cyc(); n++; end
        check("busy_seen", cm_busy, 1);
        repeat (3) cyc();
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_tx", {31'd0, core_tx_o}, 0);
        check("mid_rst_sbusy", {31'd0, sched_busy_o}, 0);
        check("mid_rst_sch", {30'd0, sched_ch_o}, 0);
        check("mid_rst_src", core_src_o, 0);
        check("mid_rst_bytes", core_bytes_o, 0);
        check("mid_rst_done", {28'd0, ch_done_o}, 0);
        tx_q.delete(); done_q.delete(); m_ptr = 0; prev_hs = 0;
        cyc(); cyc();
        rst_n = 1;
        cm_len = 3;
        #1;
        check("post_rst_idle", {31'd0, sched_busy_o}, 0);
        base = gnt_log.size();
        set_desc(3, 32'hB000, 32'hB100, 8, 2);
        set_desc(0, 32'hC000, 32'hC100, 8, 2);
        drain();
        check("post_rst_first", gnt_log.size() > base ? gnt_log[base] : -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
